// File: rtl/xbar7_sw_alloc_pkg.sv
// rtl/xbar7_sw_alloc_pkg.sv - shared constants and types for the 7-port switch allocator
package xbar7_sw_alloc_pkg;
  localparam int NPORT     = 7;
  localparam int FLIT_W    = 23;
  localparam int PAYLOAD_W = 20;
  localparam int TARG_W    = 3;

  typedef logic [TARG_W-1:0] port_t;

  localparam port_t TARG_NONE = 3'd0;
endpackage

// File: rtl/xbar7_sw_alloc_rr_arb7.sv
// rtl/xbar7_sw_alloc_rr_arb7.sv - 7-request round-robin arbiter with pointer register
module rr_arb7
  import xbar7_sw_alloc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic             upd,
  output logic [NPORT-1:0] gnt
);
  port_t      ptr;
  port_t      idx;
  logic       found;
  logic [3:0] j;

  // Scan ptr, ptr+1, ... modulo 7; the first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NPORT; i++) begin
      j = {1'b0, ptr} + 4'(i);
      if (j >= 4'd7) j = j - 4'd7;
      if (!found && req[j[2:0]]) begin
        found       = 1'b1;
        gnt[j[2:0]] = 1'b1;
        idx         = j[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (upd && found) ptr <= (idx == port_t'(NPORT - 1)) ? '0 : idx + 3'd1;
  end
endmodule

// File: rtl/xbar7_sw_alloc.sv
// rtl/xbar7_sw_alloc.sv - credit-gated per-output round-robin switch allocator and crossbar launch
// Optional wormhole output locking when SA_WORMHOLE_EN is defined.
module xbar7_sw_alloc
  import xbar7_sw_alloc_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CRW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORT-1:0]  req_v,
  input  logic [FLIT_W-1:0] in_flit1,
  input  logic [FLIT_W-1:0] in_flit2,
  input  logic [FLIT_W-1:0] in_flit3,
  input  logic [FLIT_W-1:0] in_flit4,
  input  logic [FLIT_W-1:0] in_flit5,
  input  logic [FLIT_W-1:0] in_flit6,
  input  logic [FLIT_W-1:0] in_flit7,
  input  logic [NPORT-1:0]  req_tail,
  output logic [NPORT-1:0]  req_rdy,
  input  logic [NPORT-1:0]  cr_ret,
  output logic [FLIT_W-1:0] xb_in1,
  output logic [FLIT_W-1:0] xb_in2,
  output logic [FLIT_W-1:0] xb_in3,
  output logic [FLIT_W-1:0] xb_in4,
  output logic [FLIT_W-1:0] xb_in5,
  output logic [FLIT_W-1:0] xb_in6,
  output logic [FLIT_W-1:0] xb_in7,
  output logic [NPORT-1:0]  cb_ctrl,
  output logic              drop_err
);
  logic [FLIT_W-1:0] flit   [NPORT];
  logic [FLIT_W-1:0] xb_q   [NPORT];
  logic [CRW-1:0]    credit [NPORT];
  logic [NPORT-1:0]  req_m  [NPORT];
  logic [NPORT-1:0]  gnt_m  [NPORT];
  logic [NPORT-1:0]  gnt_any, win_tail, upd, gnt_in, drop;
  port_t             gout   [NPORT];

  assign flit = '{in_flit1, in_flit2, in_flit3, in_flit4, in_flit5, in_flit6, in_flit7};
  assign {xb_in7, xb_in6, xb_in5, xb_in4, xb_in3, xb_in2, xb_in1} =
         {xb_q[6], xb_q[5], xb_q[4], xb_q[3], xb_q[2], xb_q[1], xb_q[0]};

`ifdef SA_WORMHOLE_EN
  logic [NPORT-1:0] lock_v, held;
  port_t            lock_src [NPORT];

  always_comb begin
    held = '0;
    for (int p = 0; p < NPORT; p++)
      for (int k = 0; k < NPORT; k++)
        if (lock_v[p] && lock_src[p] == port_t'(k)) held[k] = 1'b1;
  end
`endif

  // A locked-in source is routed by its lock, never by its target bits.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      for (int k = 0; k < NPORT; k++) begin
`ifdef SA_WORMHOLE_EN
        if (held[k]) req_m[p][k] = req_v[k] && lock_v[p] && (lock_src[p] == port_t'(k));
        else         req_m[p][k] = req_v[k] && !lock_v[p] && (flit[k][TARG_W-1:0] == port_t'(p + 1));
`else
        req_m[p][k] = req_v[k] && (flit[k][TARG_W-1:0] == port_t'(p + 1));
`endif
      end
      if (credit[p] == '0) req_m[p] = '0;
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_arb
    rr_arb7 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req_m[p]),
      .upd (upd[p]),
      .gnt (gnt_m[p])
    );
  end

  always_comb begin
    gnt_in = '0;
    drop   = '0;
    for (int k = 0; k < NPORT; k++) gout[k] = TARG_NONE;
    for (int p = 0; p < NPORT; p++) begin
      gnt_any[p]  = |gnt_m[p];
      win_tail[p] = |(gnt_m[p] & req_tail);
`ifdef SA_WORMHOLE_EN
      upd[p] = win_tail[p];
`else
      // A tail grant is a grant, so this is just gnt_any.
      upd[p] = gnt_any[p] | win_tail[p];
`endif
      for (int k = 0; k < NPORT; k++)
        if (gnt_m[p][k]) begin
          gnt_in[k] = 1'b1;
          gout[k]   = port_t'(p + 1);
        end
    end
    for (int k = 0; k < NPORT; k++) begin
`ifdef SA_WORMHOLE_EN
      drop[k] = req_v[k] && !held[k] && (flit[k][TARG_W-1:0] == TARG_NONE);
`else
      drop[k] = req_v[k] && (flit[k][TARG_W-1:0] == TARG_NONE);
`endif
    end
  end

  assign req_rdy = gnt_in | drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      cb_ctrl  <= '0;
      drop_err <= 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        xb_q[k]   <= '0;
        credit[k] <= CRW'(CREDITS);
      end
    end else begin
      cb_ctrl  <= gnt_in;
      drop_err <= |drop;
      for (int k = 0; k < NPORT; k++)
        if (gnt_in[k]) xb_q[k] <= {flit[k][FLIT_W-1:TARG_W], gout[k]};
      for (int p = 0; p < NPORT; p++) begin
        if (gnt_any[p] && !cr_ret[p])
          credit[p] <= credit[p] - CRW'(1);
        else if (!gnt_any[p] && cr_ret[p] && credit[p] != CRW'(CREDITS))
          credit[p] <= credit[p] + CRW'(1);
      end
    end
  end

`ifdef SA_WORMHOLE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_v <= '0;
      for (int p = 0; p < NPORT; p++) lock_src[p] <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++)
        if (gnt_any[p]) begin
          if (win_tail[p]) lock_v[p] <= 1'b0;
          else if (!lock_v[p]) begin
            lock_v[p] <= 1'b1;
            for (int k = 0; k < NPORT; k++)
              if (gnt_m[p][k]) lock_src[p] <= port_t'(k);
          end
        end
    end
  end
`endif

  // A credit returned to an already-full counter is a downstream protocol violation.
  always_ff @(posedge clk) begin
    if (!rst)
      for (int p = 0; p < NPORT; p++)
        assert (!(cr_ret[p] && !gnt_any[p] && credit[p] == CRW'(CREDITS)));
  end
endmodule

// File: tb/tb_xbar7_sw_alloc.sv
// tb/tb_xbar7_sw_alloc.sv - self-checking bench for xbar7_sw_alloc against a behavioural allocator model
module tb_xbar7_sw_alloc;
  localparam int CREDITS = 4;
`ifdef SA_WORMHOLE_EN
  localparam bit WORM = 1'b1;
`else
  localparam bit WORM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  req_v, req_tail, cr_ret, req_rdy, cb_ctrl;
  logic        drop_err;
  logic [22:0] flit [7];
  logic [22:0] xb   [7];

  always #5 clk = ~clk;

  xbar7_sw_alloc #(.CREDITS(CREDITS), .CRW(3)) dut (
    .clk(clk), .rst(rst), .req_v(req_v),
    .in_flit1(flit[0]), .in_flit2(flit[1]), .in_flit3(flit[2]), .in_flit4(flit[3]),
    .in_flit5(flit[4]), .in_flit6(flit[5]), .in_flit7(flit[6]),
    .req_tail(req_tail), .req_rdy(req_rdy), .cr_ret(cr_ret),
    .xb_in1(xb[0]), .xb_in2(xb[1]), .xb_in3(xb[2]), .xb_in4(xb[3]),
    .xb_in5(xb[4]), .xb_in6(xb[5]), .xb_in7(xb[6]),
    .cb_ctrl(cb_ctrl), .drop_err(drop_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_credit [7];
  int          m_rr     [7];
  int          m_lock_src [7];
  bit          m_lock_v [7];
  logic [22:0] m_xb [7];
  logic [6:0]  obs_rdy;
  int          grants_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output index input k competes for this cycle, -1 for none, -2 for a discard.
  function automatic int wants(input int k);
    int t;
    if (!req_v[k]) return -1;
    if (WORM)
      for (int q = 0; q < 7; q++)
        if (m_lock_v[q] && m_lock_src[q] == k) return q;
    t = int'(flit[k][2:0]);
    if (t == 0) return -2;
    if (WORM && m_lock_v[t-1]) return -1;
    return t - 1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 7; p++) begin
      m_credit[p] = CREDITS;
      m_rr[p] = 0;
      m_lock_v[p] = 1'b0;
      m_lock_src[p] = 0;
      m_xb[p] = '0;
    end
  endtask

  task automatic clear_in();
    req_v = '0;
    req_tail = '0;
    cr_ret = '0;
  endtask

  task automatic drive(input int k, input logic [19:0] pl, input logic [2:0] t, input logic tl);
    req_v[k] = 1'b1;
    flit[k] = {pl, t};
    req_tail[k] = tl;
  endtask

  task automatic do_reset();
    clear_in();
    for (int k = 0; k < 7; k++) flit[k] = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("reset_cb_ctrl", cb_ctrl, 0);
    chk("reset_drop_err", drop_err, 0);
    chk("reset_req_rdy", req_rdy, 0);
    for (int k = 0; k < 7; k++) chk($sformatf("reset_xb_in%0d", k + 1), xb[k], 0);
  endtask

  // One clock: predict grants, check req_rdy mid-cycle, then registered outputs after the edge.
  task automatic do_cycle();
    int         win [7];
    logic [6:0] exp_rdy, m_cb;
    logic       m_drop;
    int         k, w, dup;
    exp_rdy = '0;
    for (int p = 0; p < 7; p++) begin
      win[p] = -1;
      if (m_credit[p] > 0)
        for (int i = 0; i < 7; i++) begin
          k = (m_rr[p] + i) % 7;
          if (win[p] < 0 && wants(k) == p) win[p] = k;
        end
      if (win[p] >= 0) exp_rdy[win[p]] = 1'b1;
    end
    m_drop = 1'b0;
    for (int j = 0; j < 7; j++)
      if (wants(j) == -2) begin
        exp_rdy[j] = 1'b1;
        m_drop = 1'b1;
      end
    @(negedge clk);
    obs_rdy = req_rdy;
    chk("req_rdy", req_rdy, exp_rdy);
    @(posedge clk);
    m_cb = '0;
    for (int p = 0; p < 7; p++) begin
      w = win[p];
      if (w >= 0) begin
        m_cb[w] = 1'b1;
        m_xb[w] = {flit[w][22:3], 3'(p + 1)};
        if (!WORM || req_tail[w]) m_rr[p] = (w + 1) % 7;
        if (WORM) begin
          if (req_tail[w]) m_lock_v[p] = 1'b0;
          else if (!m_lock_v[p]) begin
            m_lock_v[p] = 1'b1;
            m_lock_src[p] = w;
          end
        end
        if (!cr_ret[p]) m_credit[p]--;
      end else if (cr_ret[p] && m_credit[p] < CREDITS) begin
        m_credit[p]++;
      end
    end
    #1;
    chk("cb_ctrl", cb_ctrl, m_cb);
    chk("drop_err", drop_err, m_drop);
    for (int j = 0; j < 7; j++) chk($sformatf("xb_in%0d", j + 1), xb[j], m_xb[j]);
    grants_seen += $countones(cb_ctrl);
    dup = 0;
    for (int a = 0; a < 7; a++)
      for (int b = a + 1; b < 7; b++)
        if (cb_ctrl[a] && cb_ctrl[b] && xb[a][2:0] == xb[b][2:0]) dup++;
    chk("cb_unique_target", dup, 0);
  endtask

  initial begin
    logic [6:0] seq [4];
    seq = '{7'b0000001, 7'b0000010, 7'b0001000, 7'b0000001};
    grants_seen = 0;
    do_reset();

    // Single request: input 3 -> output 5
    clear_in();
    drive(2, 20'hABCDE, 3'd5, 1'b1);
    do_cycle();
    chk("single_rdy", obs_rdy, 7'b0000100);
    chk("single_cb", cb_ctrl, 7'b0000100);
    chk("single_xb3", xb[2], 23'h55E6F5);

    // Contention on output 2 from inputs 1, 2, 4
    clear_in();
    drive(0, 20'h11111, 3'd2, 1'b1);
    drive(1, 20'h22222, 3'd2, 1'b1);
    drive(3, 20'h44444, 3'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      chk($sformatf("contention_%0d", i), cb_ctrl, seq[i]);
    end
    clear_in();
    cr_ret = 7'b0000010;
    repeat (4) do_cycle();

    // Credit exhaustion on output 7
    clear_in();
    drive(5, 20'h66666, 3'd7, 1'b1);
    grants_seen = 0;
    repeat (6) do_cycle();
    chk("exhaust_grants", grants_seen, 4);
    chk("exhaust_rdy6", obs_rdy[5], 0);
    cr_ret[6] = 1'b1;
    do_cycle();
    chk("ret_pulse_cycle_cb6", cb_ctrl[5], 0);
    cr_ret = '0;
    do_cycle();
    chk("ret_next_cycle_cb6", cb_ctrl[5], 1);
    do_cycle();
    chk("ret_only_one_cb6", cb_ctrl[5], 0);
    chk("exhaust_total", grants_seen, 5);
    clear_in();
    cr_ret = 7'b1000000;
    repeat (4) do_cycle();

    // Grant and return together at credit 1 on output 1
    clear_in();
    drive(0, 20'h0F0F0, 3'd1, 1'b1);
    repeat (3) do_cycle();
    cr_ret = 7'b0000001;
    do_cycle();
    chk("simul_grant", cb_ctrl[0], 1);
    cr_ret = '0;
    do_cycle();
    chk("simul_credit_kept", cb_ctrl[0], 1);
    do_cycle();
    chk("simul_now_empty", cb_ctrl[0], 0);
    clear_in();
    cr_ret = 7'b0000001;
    repeat (4) do_cycle();

    // Target 0 discard on input 7
    clear_in();
    drive(6, 20'h12345, 3'd0, 1'b1);
    do_cycle();
    chk("drop_rdy7", obs_rdy[6], 1);
    chk("drop_err_pulse", drop_err, 1);
    chk("drop_cb7", cb_ctrl[6], 0);
    clear_in();
    do_cycle();
    chk("drop_err_clears", drop_err, 0);

    // Random traffic against the model
    repeat (400) begin
      clear_in();
      for (int k = 0; k < 7; k++)
        if ($urandom_range(1, 0) == 1)
          drive(k, 20'($urandom), 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
      for (int p = 0; p < 7; p++)
        if (m_credit[p] < CREDITS && $urandom_range(2, 0) == 0) cr_ret[p] = 1'b1;
      do_cycle();
    end

`ifdef SA_WORMHOLE_EN
    // Three-flit packet from input 2 holds output 4 against input 5
    do_reset();
    drive(1, 20'hAAAA1, 3'd4, 1'b0);
    drive(4, 20'h55555, 3'd4, 1'b1);
    do_cycle();
    chk("worm_head", cb_ctrl, 7'b0000010);
    flit[1] = {20'hAAAA2, 3'd4};
    do_cycle();
    chk("worm_body", cb_ctrl, 7'b0000010);
    flit[1] = {20'hAAAA3, 3'd4};
    req_tail[1] = 1'b1;
    do_cycle();
    chk("worm_tail", cb_ctrl, 7'b0000010);
    req_v[1] = 1'b0;
    req_tail[1] = 1'b0;
    do_cycle();
    chk("worm_after_tail", cb_ctrl, 7'b0010000);

    // Reset mid-packet drops the lock
    do_reset();
    drive(1, 20'hBBBB1, 3'd4, 1'b0);
    drive(4, 20'h55555, 3'd4, 1'b1);
    do_cycle();
    chk("worm_head2", cb_ctrl, 7'b0000010);
    do_reset();
    drive(4, 20'h55556, 3'd4, 1'b1);
    do_cycle();
    chk("worm_unlocked_by_rst", cb_ctrl, 7'b0010000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
